prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
Program loader and run sequencer, directly upstream of the single-cycle core's instruction ROM and PC.
- Accepts a stream of 9-bit machine-code words over a valid/ready handshake and writes them into instruction memory starting at address 0.
- Holds the core in reset while loading, then releases it and counts execution cycles until the core raises done.
- Re-asserts core reset after done, leaving the block ready for the next program.

Parameters:
D, 10, instruction address width; matches the core's program counter width.
W, 9, machine-code word width.
CW, 16, width of the execution cycle counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
load_start  input  1  single-cycle request to begin loading a program
in_valid  input  1  in_data holds a valid word
in_data  input  W  machine-code word
in_last  input  1  marks the final word of the program; qualified by in_valid
in_ready  output  1  loader can accept a word this cycle
imem_we  output  1  instruction memory write enable
imem_addr  output  D  instruction memory write address
imem_wdata  output  W  instruction memory write data
core_reset  output  1  active-high reset to the core (PC, reg_file)
core_done  input  1  done flag from the core (all-ones instruction)
busy  output  1  state is LOAD, START or RUN
run_done  output  1  state is DONE
prog_len  output  D+1  number of words accepted by the last successful load
cycle_count  output  CW  clock cycles spent in RUN; saturates at all-ones
err_overflow  output  1  last load hit the memory end without seeing in_last

Behaviour:
State set and reset values
- States: IDLE, LOAD, START, RUN, DONE.
- On reset low (asynchronous): state IDLE, address counter 0, prog_len 0, cycle_count 0, err_overflow 0.
- Reset values of the state-derived outputs: core_reset 1, in_ready 0, imem_we 0, busy 0, run_done 0.

Combinational outputs
- in_ready = (state == LOAD).
- imem_we = in_valid & in_ready.
- imem_addr = address counter; imem_wdata = in_data.
- Each write is therefore presented in the same cycle as the handshake, with no registering.
- core_reset = 1 in every state except RUN.

IDLE
- load_start -> LOAD; address counter cleared to 0; err_overflow cleared.

LOAD
- Each accepted word (in_valid & in_ready) increments the address counter.
- Accepted word with in_last = 1 -> prog_len = counter + 1; go to START.
- Accepted word at address 2^D - 1 with in_last = 0 -> err_overflow = 1, prog_len = 0, go to IDLE; the core never leaves reset.
- Accepted word at address 2^D - 1 with in_last = 1 -> normal completion, prog_len = 2^D.
- in_last without in_valid is ignored.

START
- Exactly one cycle with core_reset still asserted, so the PC samples reset with the program resident.
- cycle_count cleared; go to RUN.

RUN
- core_reset = 0.
- cycle_count increments every cycle and saturates at 2^CW - 1.
- core_done = 1 -> DONE; that cycle is counted.

DONE
- core_reset = 1, holding the core frozen. cycle_count and prog_len hold.
- load_start -> LOAD, with the same clearing as from IDLE.

Ignored and boundary cases
- load_start is ignored in LOAD, START and RUN.
- core_done is ignored outside RUN.
- reset low in any state (including mid-load or mid-run) returns immediately to IDLE with the reset values above. Partially written memory contents are not cleared.

Optional Feature:
Macro PROG_LOADER_CHECKSUM_EN.
- Defined: adds output checksum [W-1:0], the XOR of all words accepted in the current load. It is cleared on load_start and on reset, and holds after LOAD exits.
- Not defined: no checksum port and no checksum logic.

Test Plan:
1. Reset low mid-stream → core_reset=1, in_ready=0, prog_len=0, err_overflow=0, state IDLE.
2. load_start, then 4 words 0x1A3, 0x000, 0x055, 0x1FF (last) with no bubbles → writes to addresses 0–3 with matching data; prog_len=4; core_reset deasserts exactly 2 cycles after the last handshake.
3. Same load with in_valid dropped for 3 cycles between words 2 and 3 → no extra writes; addresses stay contiguous 0–3.
4. core_done driven high on the 7th RUN cycle → DONE entered, cycle_count=7, core_reset=1, run_done=1; a load_start in RUN one cycle earlier is ignored.
5. Stream 1024 words with in_last never set → err_overflow=1, state IDLE, core_reset stays 1; a 1024th word with in_last set instead gives prog_len=1024 and no error.
6. With PROG_LOADER_CHECKSUM_EN defined, the load from scenario 2 → checksum = 0x1A3^0x000^0x055^0x1FF = 0x009.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: program loader and run sequencer in front of the core's instruction ROM and PC.
// Latency: a write is presented in the same cycle as its handshake. The core leaves reset 2 cycles after the last word.
// Backpressure: in_ready is high for the whole of LOAD and low otherwise. The upstream source simply stalls outside LOAD.
//
// Ports:
//   clk, reset         - rising-edge clock, asynchronous active-low reset
//   load_start         - single-cycle request to begin loading (honoured in IDLE/DONE only)
//   in_valid/in_ready  - word stream handshake; in_data is the word, in_last marks the final word
//   imem_we/addr/wdata - instruction memory write port, driven combinationally from the handshake
//   core_reset         - active-high reset to the core, low only while running
//   core_done          - done flag from the core, looked at only while running
//   busy, run_done     - status: loading/starting/running, and finished
//   prog_len           - word count of the last successful load (0 after an overflow)
//   cycle_count        - cycles spent running, saturating
//   err_overflow       - last load ran off the end of memory without seeing in_last
//   checksum           - XOR of the words accepted in the current load (only with PROG_LOADER_CHECKSUM_EN)
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN

module prog_loader #(
  parameter int D  = 10,
  parameter int W  = 9,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          imem_we,
  output logic [D-1:0]  imem_addr,
  output logic [W-1:0]  imem_wdata,
  output logic          core_reset,
  input  logic          core_done,
  output logic          busy,
  output logic          run_done,
  output logic [D:0]    prog_len,
  output logic [CW-1:0] cycle_count,
  output logic          err_overflow
`ifdef PROG_LOADER_CHECKSUM_EN
  ,
  output logic [W-1:0]  checksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [D-1:0]  ADDR_MAX = '1;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_t        state;
  logic [D-1:0]  addr;
  logic          accept;

  assign in_ready   = (state == S_LOAD);
  assign accept     = in_valid & in_ready;
  assign imem_we    = accept;
  assign imem_addr  = addr;
  assign imem_wdata = in_data;
  assign core_reset = (state != S_RUN);
  assign busy       = (state == S_LOAD) || (state == S_START) || (state == S_RUN);
  assign run_done   = (state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      addr         <= '0;
      prog_len     <= '0;
      cycle_count  <= '0;
      err_overflow <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      checksum     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // DONE keeps cycle_count/prog_len visible until the next load begins
          if (load_start) begin
            state        <= S_LOAD;
            addr         <= '0;
            err_overflow <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            checksum     <= '0;
`endif
          end
        end

        S_LOAD: begin
          if (accept) begin
            // counter wraps to 0 on overflow; it is cleared again on the next load_start anyway
            addr <= addr + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            checksum <= checksum ^ in_data;
`endif
            if (in_last) begin
              // widened so a full memory (2^D words) is representable
              prog_len <= {1'b0, addr} + {{D{1'b0}}, 1'b1};
              state    <= S_START;
            end else if (addr == ADDR_MAX) begin
              // program does not fit: abandon it, core stays in reset
              err_overflow <= 1'b1;
              prog_len     <= '0;
              state        <= S_IDLE;
            end
          end
        end

        S_START: begin
          // one extra reset cycle so the PC samples reset with the program resident
          cycle_count <= '0;
          state       <= S_RUN;
        end

        S_RUN: begin
          if (cycle_count != CNT_MAX) begin
            cycle_count <= cycle_count + 1'b1;
          end
          if (core_done) begin
            state <= S_DONE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized bench for prog_loader with a cycle-level reference model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).

module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [8:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [8:0]  imem_wdata;
  logic        core_reset;
  logic        core_done = 1'b0;
  logic        busy;
  logic        run_done;
  logic [10:0] prog_len;
  logic [15:0] cycle_count;
  logic        err_overflow;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [8:0]  checksum;
`endif

  int checks = 0;
  int failures = 0;

  prog_loader dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_reset   (core_reset),
    .core_done    (core_done),
    .busy         (busy),
    .run_done     (run_done),
    .prog_len     (prog_len),
    .cycle_count  (cycle_count),
    .err_overflow (err_overflow)
`ifdef PROG_LOADER_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_LOAD = 1, M_START = 2, M_RUN = 3, M_DONE = 4;
  int         ms = M_IDLE;   // phase of the program lifecycle
  int         ma = 0;        // next memory slot to be written
  int         ml = 0;        // expected prog_len
  int         mc = 0;        // expected cycle_count
  bit         me = 0;        // expected err_overflow
  logic [8:0] mk = '0;       // expected checksum

  // writes observed on the memory port, for literal checks
  logic [9:0] wa_q[$];
  logic [8:0] wd_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      ms = M_IDLE; ma = 0; ml = 0; mc = 0; me = 0; mk = '0;
    end
    chk("core_reset",   32'(core_reset),   32'(ms != M_RUN));
    chk("in_ready",     32'(in_ready),     32'(ms == M_LOAD));
    chk("imem_we",      32'(imem_we),      32'(in_valid && ms == M_LOAD));
    chk("imem_addr",    32'(imem_addr),    32'(ma));
    chk("imem_wdata",   32'(imem_wdata),   32'(in_data));
    chk("busy",         32'(busy),         32'(ms == M_LOAD || ms == M_START || ms == M_RUN));
    chk("run_done",     32'(run_done),     32'(ms == M_DONE));
    chk("prog_len",     32'(prog_len),     32'(ml));
    chk("cycle_count",  32'(cycle_count),  32'(mc));
    chk("err_overflow", 32'(err_overflow), 32'(me));
`ifdef PROG_LOADER_CHECKSUM_EN
    chk("checksum",     32'(checksum),     32'(mk));
`endif
    if (imem_we) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
    end
    if (reset) begin
      case (ms)
        M_IDLE, M_DONE: if (load_start) begin ms = M_LOAD; ma = 0; me = 0; mk = '0; end
        M_LOAD: if (in_valid) begin
          mk = mk ^ in_data;
          if (in_last) begin
            ml = ma + 1; ms = M_START;
          end else if (ma == 1023) begin
            me = 1; ml = 0; ms = M_IDLE;
          end
          ma = (ma + 1) % 1024;
        end
        M_START: begin mc = 0; ms = M_RUN; end
        M_RUN: begin
          if (mc < 65535) mc++;
          if (core_done) ms = M_DONE;
        end
        default: ms = M_IDLE;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_load;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // bubbles carry garbage data, stray in_last and optional load_start/core_done noise
  task automatic send(input logic [8:0] d, input bit last, input int bubbles, input bit noise);
    for (int b = 0; b < bubbles; b++) begin
      in_valid   = 1'b0;
      in_data    = 9'($urandom);
      in_last    = 1'($urandom);
      load_start = noise && ($urandom_range(0, 3) == 0);
      core_done  = noise && ($urandom_range(0, 3) == 0);
      tick();
    end
    load_start = 1'b0;
    core_done  = 1'b0;
    in_valid   = 1'b1;
    in_data    = d;
    in_last    = last;
    tick();
    in_valid   = 1'b0;
    in_last    = 1'b0;
    in_data    = 9'($urandom);
  endtask

  // entered during RUN cycle 1; raises core_done in RUN cycle n
  task automatic run_prog(input int n, input bit ls_noise);
    for (int c = 1; c < n; c++) begin
      load_start = ls_noise && (c == n - 1);
      tick();
    end
    load_start = 1'b0;
    core_done  = 1'b1;
    tick();
    core_done  = 1'b0;
  endtask

  logic [8:0] prog4 [4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    prog4[0] = 9'h1A3; prog4[1] = 9'h000; prog4[2] = 9'h055; prog4[3] = 9'h1FF;

    repeat (3) tick();
    chk("lit_reset_core_reset", 32'(core_reset), 32'd1);
    chk("lit_reset_in_ready",   32'(in_ready),   32'd0);
    reset = 1'b1;
    tick();

    // back-to-back load of a 4-word program
    wa_q.delete(); wd_q.delete();
    start_load();
    for (int i = 0; i < 4; i++) send(prog4[i], i == 3, 0, 0);
    chk("lit_prog_len_4",       32'(prog_len),   32'd4);
    chk("lit_start_core_reset", 32'(core_reset), 32'd1);
`ifdef PROG_LOADER_CHECKSUM_EN
    chk("lit_checksum",         32'(checksum),   32'h009);
`endif
    chk("lit_nwrites",          32'(wa_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      chk("lit_waddr", 32'(wa_q[i]), 32'(i));
      chk("lit_wdata", 32'(wd_q[i]), 32'(prog4[i]));
    end
    tick();
    chk("lit_run_core_reset",   32'(core_reset), 32'd0);

    // done on RUN cycle 7, with an ignored load_start one cycle earlier
    run_prog(7, 1);
    chk("lit_cycle_count_7",    32'(cycle_count), 32'd7);
    chk("lit_done_run_done",    32'(run_done),    32'd1);
    chk("lit_done_core_reset",  32'(core_reset),  32'd1);

    // same program with a 3-cycle bubble before the third word
    wa_q.delete(); wd_q.delete();
    start_load();
    for (int i = 0; i < 4; i++) send(prog4[i], i == 3, (i == 2) ? 3 : 0, 0);
    chk("lit_bubble_nwrites", 32'(wa_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < wa_q.size(); i++)
      chk("lit_bubble_waddr", 32'(wa_q[i]), 32'(i));
    tick();
    run_prog(3, 0);

    // asynchronous reset in the middle of a load
    start_load();
    send(9'h011, 0, 0, 0);
    send(9'h022, 0, 0, 0);
    in_valid = 1'b1;
    in_data  = 9'h033;
    #1 reset = 1'b0;
    #1;
    chk("lit_mid_core_reset", 32'(core_reset),   32'd1);
    chk("lit_mid_in_ready",   32'(in_ready),     32'd0);
    chk("lit_mid_prog_len",   32'(prog_len),     32'd0);
    chk("lit_mid_err",        32'(err_overflow), 32'd0);
    chk("lit_mid_busy",       32'(busy),         32'd0);
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();

    // 1024 words without in_last overflows memory
    start_load();
    for (int i = 0; i < 1024; i++) send(9'($urandom), 0, 0, 0);
    chk("lit_ovf_err",        32'(err_overflow), 32'd1);
    chk("lit_ovf_busy",       32'(busy),         32'd0);
    chk("lit_ovf_prog_len",   32'(prog_len),     32'd0);
    tick();
    chk("lit_ovf_core_reset", 32'(core_reset),   32'd1);

    // 1024 words with in_last on the final word fills memory exactly
    start_load();
    for (int i = 0; i < 1024; i++) send(9'($urandom), i == 1023, 0, 0);
    chk("lit_full_prog_len",  32'(prog_len),     32'd1024);
    chk("lit_full_err",       32'(err_overflow), 32'd0);
    tick();
    run_prog(5, 0);

    // randomized programs, bubbles, noise and run lengths
    for (int t = 0; t < 25; t++) begin
      int len;
      len = $urandom_range(1, 40);
      start_load();
      for (int i = 0; i < len; i++)
        send(9'($urandom), i == len - 1, $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0, 1);
      tick();
      run_prog($urandom_range(1, 30), 1'($urandom));
      for (int k = 0; k < int'($urandom_range(0, 4)); k++) begin
        core_done = 1'($urandom);
        tick();
      end
      core_done = 1'b0;
    end

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
